// File: rtl/cpu_memif_pkg.sv
// Shared CPU package: opcode encodings, memory-stage state
// enum and small decode helpers for the data-side pipeline.
package cpu_memif_pkg;

  localparam logic [5:0] OP_AND  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_LDB  = 6'h10;
  localparam logic [5:0] OP_LDBU = 6'h11;
  localparam logic [5:0] OP_LDH  = 6'h12;
  localparam logic [5:0] OP_LDHU = 6'h13;
  localparam logic [5:0] OP_LDW  = 6'h14;
  localparam logic [5:0] OP_STB  = 6'h18;
  localparam logic [5:0] OP_STH  = 6'h19;
  localparam logic [5:0] OP_STW  = 6'h1A;

  typedef enum logic [1:0] {
    MEMIF_IDLE,
    MEMIF_REQ,
    MEMIF_RESP
  } memif_state_e;

  function automatic logic is_load(logic [5:0] op);
    return op inside {OP_LDB, OP_LDBU, OP_LDH, OP_LDHU, OP_LDW};
  endfunction

  function automatic logic is_store(logic [5:0] op);
    return op inside {OP_STB, OP_STH, OP_STW};
  endfunction

  function automatic logic is_misaligned(logic [5:0] op,
                                         logic [1:0] a);
    logic m;
    m = 1'b0;
    case (op)
      OP_LDH, OP_LDHU, OP_STH: m = a[0];
      OP_LDW, OP_STW:          m = (a != 2'b00);
      default:                 m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] store_strb(logic [5:0] op,
                                            logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      OP_STB:  s = 4'b0001 << a;
      OP_STH:  s = 4'b0011 << {a[1], 1'b0};
      OP_STW:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(logic [5:0] op,
                                             logic [31:0] w);
    logic [31:0] d;
    d = 32'h0;
    case (op)
      OP_STB:  d = {4{w[7:0]}};
      OP_STH:  d = {2{w[15:0]}};
      OP_STW:  d = w;
      default: d = 32'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_load_align.sv
// Combinational load lane extraction: picks the byte/half
// selected by the address offset and sign- or zero-extends it.
module cpu_load_align
  import cpu_memif_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{offset, 3'b000} +: 8];
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (op)
      OP_LDB:  data = {{24{b[7]}}, b};
      OP_LDBU: data = {24'h0, b};
      OP_LDH:  data = {{16{h[15]}}, h};
      OP_LDHU: data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/cpu_memif.sv
// Falcon data-side memory stage: owns p3->p4 registers, issues
// one bus transaction per aligned load/store, returns load data.
module cpu_memif
  import cpu_memif_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [5:0]  p3_op,
  input  logic [31:0] p3_alu_out,
  input  logic [31:0] p3_wdata,
  output logic [5:0]  p4_op,
  output logic [31:0] p4_alu_out,
  output logic        p4_read_pending,
  output logic        p4_write_pending,
  output logic [31:0] p4_mem_rdata,
  output logic        p4_misaligned,
  output logic        cpud_request,
  output logic        cpud_write,
  output logic [31:0] cpud_addr,
  output logic [3:0]  cpud_wstrb,
  output logic [31:0] cpud_wdata,
  input  logic        cpud_ready,
  input  logic        cpud_rvalid,
  input  logic [31:0] cpud_rdata
);

  memif_state_e state_q, state_d;

  logic [1:0]  a;
  logic        advance;
  logic        mem_op;
  logic        mis;
  logic        issue;
  logic [31:0] load_data;

  assign a       = p3_alu_out[1:0];
  assign advance = !stall;
  assign mem_op  = is_load(p3_op) | is_store(p3_op);
  assign mis     = mem_op && is_misaligned(p3_op, a);
  assign issue   = advance && (state_q == MEMIF_IDLE)
                && mem_op && !mis;

  // Aligns against the op/offset already latched in p4.
  cpu_load_align u_align (
    .op     (p4_op),
    .offset (p4_alu_out[1:0]),
    .rdata  (cpud_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= MEMIF_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEMIF_IDLE: if (issue) state_d = MEMIF_REQ;
      MEMIF_REQ:
        if (cpud_ready)
          state_d = cpud_write ? MEMIF_IDLE : MEMIF_RESP;
      MEMIF_RESP: if (cpud_rvalid) state_d = MEMIF_IDLE;
      default:    state_d = MEMIF_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p4_op            <= OP_AND;
      p4_alu_out       <= 32'h0;
      p4_misaligned    <= 1'b0;
      p4_read_pending  <= 1'b0;
      p4_write_pending <= 1'b0;
      p4_mem_rdata     <= 32'h0;
      cpud_request     <= 1'b0;
      cpud_write       <= 1'b0;
      cpud_addr        <= 32'h0;
      cpud_wstrb       <= 4'h0;
      cpud_wdata       <= 32'h0;
    end else begin
      if (advance) begin
        p4_op         <= p3_op;
        p4_alu_out    <= p3_alu_out;
        p4_misaligned <= mis;
      end
      if (issue) begin
        cpud_request     <= 1'b1;
        cpud_write       <= is_store(p3_op);
        cpud_addr        <= {p3_alu_out[31:2], 2'b00};
        cpud_wstrb       <= store_strb(p3_op, a);
        cpud_wdata       <= store_data(p3_op, p3_wdata);
        p4_read_pending  <= is_load(p3_op);
        p4_write_pending <= is_store(p3_op);
      end
      if (state_q == MEMIF_REQ && cpud_ready) begin
        cpud_request     <= 1'b0;
        p4_write_pending <= 1'b0;
      end
      if (state_q == MEMIF_RESP && cpud_rvalid) begin
        p4_mem_rdata    <= load_data;
        p4_read_pending <= 1'b0;
      end
    end
  end

  // Completion must hold the pipe while a transaction is open.
  a_advance_idle: assert property (
    @(posedge clock) disable iff (reset)
    !stall |-> state_q == MEMIF_IDLE);

endmodule

// File: tb/tb_cpu_memif.sv
// Directed self-checking bench for cpu_memif with a simple
// completion-stall model and hand-computed expectations.
module tb_cpu_memif;
  import cpu_memif_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        hold;
  logic [5:0]  p3_op;
  logic [31:0] p3_alu_out;
  logic [31:0] p3_wdata;
  logic [5:0]  p4_op;
  logic [31:0] p4_alu_out;
  logic        p4_read_pending;
  logic        p4_write_pending;
  logic [31:0] p4_mem_rdata;
  logic        p4_misaligned;
  logic        cpud_request;
  logic        cpud_write;
  logic [31:0] cpud_addr;
  logic [3:0]  cpud_wstrb;
  logic [31:0] cpud_wdata;
  logic        cpud_ready;
  logic        cpud_rvalid;
  logic [31:0] cpud_rdata;

  int checks = 0;
  int fails  = 0;
  int accepts = 0;

  always #5 clock = ~clock;

  assign stall = hold | p4_read_pending | p4_write_pending;

  always @(posedge clock)
    if (!reset && cpud_request && cpud_ready) accepts++;

  cpu_memif dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .p3_op            (p3_op),
    .p3_alu_out       (p3_alu_out),
    .p3_wdata         (p3_wdata),
    .p4_op            (p4_op),
    .p4_alu_out       (p4_alu_out),
    .p4_read_pending  (p4_read_pending),
    .p4_write_pending (p4_write_pending),
    .p4_mem_rdata     (p4_mem_rdata),
    .p4_misaligned    (p4_misaligned),
    .cpud_request     (cpud_request),
    .cpud_write       (cpud_write),
    .cpud_addr        (cpud_addr),
    .cpud_wstrb       (cpud_wstrb),
    .cpud_wdata       (cpud_wdata),
    .cpud_ready       (cpud_ready),
    .cpud_rvalid      (cpud_rvalid),
    .cpud_rdata       (cpud_rdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_op"},   {26'h0, p4_op}, 32'h0);
    chk({tag, "_alu"},  p4_alu_out, 32'h0);
    chk({tag, "_rd"},   p4_mem_rdata, 32'h0);
    chk({tag, "_pend"}, {30'h0, p4_read_pending,
                         p4_write_pending}, 32'h0);
    chk({tag, "_mis"},  {31'h0, p4_misaligned}, 32'h0);
    chk({tag, "_req"},  {30'h0, cpud_request, cpud_write},
        32'h0);
    chk({tag, "_addr"}, cpud_addr, 32'h0);
    chk({tag, "_strb"}, {28'h0, cpud_wstrb}, 32'h0);
    chk({tag, "_wd"},   cpud_wdata, 32'h0);
  endtask

  task automatic drive(input logic [5:0] op,
                       input logic [31:0] addr,
                       input logic [31:0] wd);
    p3_op      = op;
    p3_alu_out = addr;
    p3_wdata   = wd;
  endtask

  initial begin
    reset = 1'b1;
    hold = 1'b0;
    cpud_ready = 1'b0;
    cpud_rvalid = 1'b0;
    cpud_rdata = 32'h0;
    drive(OP_AND, 32'h0, 32'h0);
    tick();
    tick();
    chk_reset("rst");
    reset = 1'b0;

    // LDB at 0x1003, best-case timing
    drive(OP_LDB, 32'h1003, 32'h0);
    cpud_ready = 1'b1;
    tick();
    chk("ldb_op", {26'h0, p4_op}, {26'h0, OP_LDB});
    chk("ldb_req", {30'h0, cpud_request, cpud_write}, 32'h2);
    chk("ldb_addr", cpud_addr, 32'h1000);
    chk("ldb_strb", {28'h0, cpud_wstrb}, 32'h0);
    chk("ldb_rp", {31'h0, p4_read_pending}, 32'h1);
    drive(OP_AND, 32'h0, 32'h0);
    tick();
    chk("ldb_req_drop", {31'h0, cpud_request}, 32'h0);
    chk("ldb_rp_resp", {31'h0, p4_read_pending}, 32'h1);
    cpud_ready = 1'b0;
    cpud_rvalid = 1'b1;
    cpud_rdata = 32'h80FF_FF12;
    tick();
    cpud_rvalid = 1'b0;
    chk("ldb_rp_done", {31'h0, p4_read_pending}, 32'h0);
    chk("ldb_data", p4_mem_rdata, 32'hFFFF_FF80);

    // LDBU same address and data
    drive(OP_LDBU, 32'h1003, 32'h0);
    cpud_ready = 1'b1;
    tick();
    drive(OP_AND, 32'h0, 32'h0);
    tick();
    cpud_ready = 1'b0;
    cpud_rvalid = 1'b1;
    tick();
    cpud_rvalid = 1'b0;
    chk("ldbu_rp", {31'h0, p4_read_pending}, 32'h0);
    chk("ldbu_data", p4_mem_rdata, 32'h0000_0080);

    // STH with ready delayed 3 cycles, stray rvalid in REQ
    accepts = 0;
    drive(OP_STH, 32'h2002, 32'h1234_ABCD);
    tick();
    drive(OP_AND, 32'h0, 32'h0);
    chk("sth_wp", {31'h0, p4_write_pending}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cpud_rvalid = (i == 1);
      cpud_rdata = 32'hDEAD_BEEF;
      chk("sth_req_hold", {30'h0, cpud_request, cpud_write},
          32'h3);
      chk("sth_addr", cpud_addr, 32'h2000);
      chk("sth_strb", {28'h0, cpud_wstrb}, 32'hC);
      chk("sth_wdata", cpud_wdata, 32'hABCD_ABCD);
      tick();
    end
    cpud_rvalid = 1'b0;
    chk("sth_wp_wait", {31'h0, p4_write_pending}, 32'h1);
    cpud_ready = 1'b1;
    tick();
    cpud_ready = 1'b0;
    chk("sth_wp_done", {31'h0, p4_write_pending}, 32'h0);
    chk("sth_req_done", {31'h0, cpud_request}, 32'h0);
    tick();
    chk("sth_accepts", accepts, 32'd1);
    chk("stray_rdata", p4_mem_rdata, 32'h0000_0080);

    // STB at 0x8001
    drive(OP_STB, 32'h8001, 32'h0000_00AA);
    cpud_ready = 1'b1;
    tick();
    drive(OP_AND, 32'h0, 32'h0);
    chk("stb_strb", {28'h0, cpud_wstrb}, 32'h2);
    chk("stb_wdata", cpud_wdata, 32'hAAAA_AAAA);
    tick();
    cpud_ready = 1'b0;
    chk("stb_wp_done", {31'h0, p4_write_pending}, 32'h0);

    // Misaligned LDW, then an ALU op advances at once
    drive(OP_LDW, 32'h3001, 32'h0);
    tick();
    chk("mis_flag", {31'h0, p4_misaligned}, 32'h1);
    chk("mis_req", {31'h0, cpud_request}, 32'h0);
    chk("mis_pend", {30'h0, p4_read_pending,
                     p4_write_pending}, 32'h0);
    drive(OP_ADD, 32'h55, 32'h0);
    tick();
    chk("mis_next_op", {26'h0, p4_op}, {26'h0, OP_ADD});
    chk("mis_next_alu", p4_alu_out, 32'h55);
    chk("mis_clear", {31'h0, p4_misaligned}, 32'h0);

    // LDH at 0x4002, stall held, rvalid 5 cycles after accept
    drive(OP_LDH, 32'h4002, 32'h0);
    cpud_ready = 1'b1;
    tick();
    hold = 1'b1;
    drive(OP_AND, 32'h0, 32'h0);
    tick();
    cpud_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ldh_rp_wait", {31'h0, p4_read_pending}, 32'h1);
      tick();
    end
    cpud_rvalid = 1'b1;
    cpud_rdata = 32'h8000_0000;
    chk("ldh_rp_last", {31'h0, p4_read_pending}, 32'h1);
    tick();
    cpud_rvalid = 1'b0;
    chk("ldh_rp_done", {31'h0, p4_read_pending}, 32'h0);
    chk("ldh_data", p4_mem_rdata, 32'hFFFF_8000);
    chk("ldh_op_held", {26'h0, p4_op}, {26'h0, OP_LDH});
    hold = 1'b0;

    // Reset during RESP, then a stray rvalid
    drive(OP_LDW, 32'h5000, 32'h0);
    cpud_ready = 1'b1;
    tick();
    drive(OP_AND, 32'h0, 32'h0);
    tick();
    cpud_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset("rst_mid");
    tick();
    reset = 1'b0;
    cpud_rvalid = 1'b1;
    cpud_rdata = 32'h1111_1111;
    tick();
    cpud_rvalid = 1'b0;
    chk("rst_stray_rd", p4_mem_rdata, 32'h0);
    chk("rst_stray_rp", {31'h0, p4_read_pending}, 32'h0);

    // Next load completes normally
    drive(OP_LDW, 32'h6000, 32'h0);
    cpud_ready = 1'b1;
    tick();
    drive(OP_AND, 32'h0, 32'h0);
    tick();
    cpud_ready = 1'b0;
    cpud_rvalid = 1'b1;
    cpud_rdata = 32'hCAFE_F00D;
    tick();
    cpud_rvalid = 1'b0;
    chk("post_rst_ld", p4_mem_rdata, 32'hCAFE_F00D);

    // Back-to-back SW, LDW, ADD with ready high
    accepts = 0;
    cpud_ready = 1'b1;
    drive(OP_STW, 32'h7004, 32'h0102_0304);
    tick();
    chk("b2b_sw_strb", {28'h0, cpud_wstrb}, 32'hF);
    chk("b2b_sw_wd", cpud_wdata, 32'h0102_0304);
    drive(OP_LDW, 32'h7008, 32'h0);
    tick();
    chk("b2b_sw_done", {31'h0, p4_write_pending}, 32'h0);
    tick();
    chk("b2b_ld_req", {30'h0, cpud_request, cpud_write}, 32'h2);
    chk("b2b_ld_addr", cpud_addr, 32'h7008);
    drive(OP_ADD, 32'h99, 32'h0);
    tick();
    cpud_rvalid = 1'b1;
    cpud_rdata = 32'h0BAD_CAFE;
    tick();
    cpud_rvalid = 1'b0;
    chk("b2b_ld_data", p4_mem_rdata, 32'h0BAD_CAFE);
    tick();
    cpud_ready = 1'b0;
    chk("b2b_alu_op", {26'h0, p4_op}, {26'h0, OP_ADD});
    chk("b2b_alu_pend", {30'h0, p4_read_pending,
                         p4_write_pending}, 32'h0);
    chk("b2b_accepts", accepts, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/cpu_memif.md
# cpu_memif

Pipeline memory-access stage for the Falcon CPU data side. It sits between execute (p3) and completion (p4) and owns the p3→p4 pipeline registers. It issues at most one data-bus transaction per load or store, with lane steering and byte strobes. It returns aligned, sign- or zero-extended load data and read/write pending flags for the completion stage, which stalls on those flags.

## Interface
Parameters: none. Opcodes come from `cpu.vh`.

Ports:
- `clock`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `stall`  in  1  pipeline hold from completion; when 1, p4 registers keep their values
- `p3_op`  in  6  execute-stage opcode
- `p3_alu_out`  in  32  ALU result; effective address for LD*/ST*
- `p3_wdata`  in  32  store data; low byte/half/word used
- `p4_op`  out  6  registered opcode
- `p4_alu_out`  out  32  registered ALU result/address
- `p4_read_pending`  out  1  load issued, response not yet captured
- `p4_write_pending`  out  1  store issued, not yet accepted
- `p4_mem_rdata`  out  32  extended load data, valid when the p4 op is a load and `p4_read_pending`=0
- `p4_misaligned`  out  1  p4 op is a misaligned LDH/LDHU/LDW/STH/STW; no bus access made
- `cpud_request`  out  1  bus request valid
- `cpud_write`  out  1  1=store, 0=load
- `cpud_addr`  out  32  word-aligned address ({addr[31:2],2'b00})
- `cpud_wstrb`  out  4  byte strobes; 0000 on reads
- `cpud_wdata`  out  32  lane-replicated store data
- `cpud_ready`  in  1  bus accepts request this cycle
- `cpud_rvalid`  in  1  read response valid, one cycle per accepted read
- `cpud_rdata`  in  32  read response word

## Operation
- **Advance** (`stall`=0, rising edge): `p4_op`←`p3_op`; `p4_alu_out`←`p3_alu_out`. Lane offset `a`=`p3_alu_out[1:0]`.
- **Alignment:**
  - LDB/LDBU/STB: always aligned.
  - LDH/LDHU/STH: misaligned when `a[0]`=1.
  - LDW/STW: misaligned when `a`≠0.
- **Misaligned access:** `p4_misaligned`←1; no request; pending flags stay 0.
- **Aligned load:** `cpud_request`←1, `cpud_write`←0, `p4_read_pending`←1.
- **Aligned store:** `cpud_request`←1, `cpud_write`←1, `p4_write_pending`←1.
  - Strobes: STB `0001<<a`; STH `0011<<{a[1],0}`; STW `1111`.
  - Data: STB `{4{wdata[7:0]}}`; STH `{2{wdata[15:0]}}`; STW `wdata`.
- **Non-memory op:** request 0, pending 0, misaligned 0.
- **State machine** (2 bits): IDLE, REQ, RESP.
  - IDLE → REQ on advance with an aligned memory op.
  - REQ: `cpud_request`=1 and all `cpud_*` outputs held stable until `cpud_ready`=1.
    - Store accepted: `p4_write_pending`←0, go IDLE.
    - Load accepted: `cpud_request`←0, go RESP.
  - RESP: on `cpud_rvalid`, capture the lane into `p4_mem_rdata`, `p4_read_pending`←0, go IDLE.
- **Load extraction** by stored `a`:
  - LDB: sign-extend byte `a`.
  - LDBU: zero-extend byte `a`.
  - LDH: sign-extend half `a[1]`.
  - LDHU: zero-extend half `a[1]`.
  - LDW: full word.
- **Stall interaction:**
  - `stall`=1 never cancels or reissues an in-flight transaction.
  - Exactly one bus transaction per advanced memory op.
  - A new op is not accepted while state≠IDLE. The completion stall guarantees this; an advance while state≠IDLE is an assertion failure.
- **Stray responses:** `cpud_rvalid` in IDLE or REQ is ignored.

## Timing
- **Reset values:** `p4_op`=`OP_AND` encoding 0 (bubble), `p4_alu_out`=0, `p4_mem_rdata`=0, all pending/misaligned/request/write=0, `cpud_addr`=0, `cpud_wstrb`=0, `cpud_wdata`=0, state IDLE.
- **Reset mid-transaction:** the transaction is abandoned. A later `cpud_rvalid` is ignored.
- **Load, best case:**
  - Cycle 1: p4 holds the load, request high, `cpud_ready`=1.
  - Cycle 2: `cpud_rvalid`.
  - Cycle 3: `p4_read_pending`=0, data valid.
  - Result: 2 stall cycles.
- **Store, best case:** `cpud_ready`=1 in cycle 1 → cycle 2 `p4_write_pending`=0. Result: 1 stall cycle.
- **Registering:** every output is registered. No combinational path from `cpud_*` inputs to outputs.

## Structure
- Opcode constants come from the shared `cpu.vh`.
- Add the state enum (`MEMIF_IDLE/REQ/RESP`) to the shared CPU package.
- One sub-module, `cpu_load_align`: purely combinational. Inputs op, offset, rdata; output extended data. Reused by any future cache path.

## Test plan
- LDB at 0x1003, rdata 0x80FF_FF12 → `p4_mem_rdata`=0xFFFF_FF80; LDBU → 0x0000_0080.
- STH 0x1234_ABCD at 0x2002 → wstrb 1100, wdata 0xABCD_ABCD, addr 0x2000; `cpud_ready` delayed 3 cycles → request held and stable, exactly one acceptance.
- LDW at 0x3001 → `p4_misaligned`=1, no request, pending 0; next op advances immediately.
- LDH at 0x4002, rvalid 5 cycles after accept, `stall` held throughout → `p4_read_pending` 1 until capture, then data 0xFFFF_8000 for rdata 0x8000_0000.
- Reset asserted during RESP, then rvalid → outputs at reset values; rvalid ignored; next load completes normally.
- Back-to-back SW, LDW, ALU op with `cpud_ready`=1 → two bus transactions, ALU op reaches p4 with pending 0.
